uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/uart_cmd_timeout.sv | 31 +++
 rtl/uart_cmd_ctrl.sv | 115 +++++++++++
 tb/tb_uart_cmd_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: parser states, frame
// constants and the opcode values consumers decode against.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_OP,
    GET_HI,
    GET_LO,
    GET_CHK
  } parser_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

  localparam logic [7:0] OP_FILTER_SEL = 8'h01;
  localparam logic [7:0] OP_NOTE       = 8'h02;

  function automatic logic [7:0] frame_chk(input logic [7:0] op,
                                           input logic [7:0] arg_hi,
                                           input logic [7:0] arg_lo);
    return op ^ arg_hi ^ arg_lo;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count sits at TIMEOUT_CYC-1.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  // A clear in the same cycle (a byte arrived) always wins over expiry.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser for SYNC/op/arg_hi/arg_lo/chk command frames with a one-deep
// valid/ready output register and single-cycle error pulses.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_arg,
  output logic        err_chk,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        busy
);

  parser_state_t state;
  logic [7:0]    op_buf;
  logic [7:0]    hi_buf;
  logic [7:0]    lo_buf;
  logic          transfer;
  logic          expire;
  logic          tmo_clear;

  assign transfer  = cmd_valid && cmd_ready;
  assign tmo_clear = rx_done || !busy;

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .enable(busy),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_SYNC;
      op_buf      <= '0;
      hi_buf      <= '0;
      lo_buf      <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_arg     <= '0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      if (transfer) begin
        cmd_valid <= 1'b0;
      end

      if (rx_done) begin
        case (state)
          WAIT_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state <= GET_OP;
              busy  <= 1'b1;
            end
          end
          GET_OP: begin
            op_buf <= rx_data;
            state  <= GET_HI;
          end
          GET_HI: begin
            hi_buf <= rx_data;
            state  <= GET_LO;
          end
          GET_LO: begin
            lo_buf <= rx_data;
            state  <= GET_CHK;
          end
          GET_CHK: begin
            state <= WAIT_SYNC;
            busy  <= 1'b0;
            // The output register is free if empty or being drained this cycle.
            if (rx_data == frame_chk(op_buf, hi_buf, lo_buf)) begin
              if (!cmd_valid || transfer) begin
                cmd_op    <= op_buf;
                cmd_arg   <= {hi_buf, lo_buf};
                cmd_valid <= 1'b1;
              end else begin
                err_overrun <= 1'b1;
              end
            end else begin
              err_chk <= 1'b1;
            end
          end
          default: begin
            state <= WAIT_SYNC;
            busy  <= 1'b0;
          end
        endcase
      end else if (expire) begin
        state       <= WAIT_SYNC;
        busy        <= 1'b0;
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios with literal
// expectations plus randomized byte streams against a frame-level model.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        err_chk;
  logic        err_timeout;
  logic        err_overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit rnd_en = 1'b0;

  uart_cmd_ctrl #(
    .SYNC_BYTE  (8'hAA),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .err_chk    (err_chk),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Called at posedge+1; the byte is sampled on the next edge, then 'gap'
  // idle cycles follow, so consecutive bytes are gap+1 edges apart.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Frame-level reference: collects the four post-sync bytes, tracks when the
  // last byte arrived, and holds at most one undelivered command.
  int          cyc = 0;
  int          last_rx = 0;
  bit          in_frame = 1'b0;
  logic [7:0]  fb[$];
  bit          m_valid = 1'b0;
  logic [7:0]  m_op = 8'h00;
  logic [15:0] m_arg = 16'h0000;
  bit          m_chk = 1'b0;
  bit          m_tmo = 1'b0;
  bit          m_ovr = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      in_frame = 1'b0;
      fb.delete();
      m_valid = 1'b0;
      m_op = 8'h00;
      m_arg = 16'h0000;
      m_chk = 1'b0;
      m_tmo = 1'b0;
      m_ovr = 1'b0;
    end else begin
      cyc++;
      m_chk = 1'b0;
      m_tmo = 1'b0;
      m_ovr = 1'b0;
      if (m_valid && cmd_ready) m_valid = 1'b0;
      if (rx_done) begin
        last_rx = cyc;
        if (!in_frame) begin
          if (rx_data == 8'hAA) begin
            in_frame = 1'b1;
            fb.delete();
          end
        end else begin
          fb.push_back(rx_data);
          if (fb.size() == 4) begin
            in_frame = 1'b0;
            if ((fb[0] ^ fb[1] ^ fb[2]) == fb[3]) begin
              if (!m_valid) begin
                m_valid = 1'b1;
                m_op = fb[0];
                m_arg = {fb[1], fb[2]};
              end else begin
                m_ovr = 1'b1;
              end
            end else begin
              m_chk = 1'b1;
            end
          end
        end
      end else if (in_frame && (cyc - last_rx == TMO)) begin
        in_frame = 1'b0;
        m_tmo = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      checkOutput("cmd_valid", cmd_valid, m_valid);
      checkOutput("cmd_op", cmd_op, m_op);
      checkOutput("cmd_arg", cmd_arg, m_arg);
      checkOutput("err_chk", err_chk, m_chk);
      checkOutput("err_timeout", err_timeout, m_tmo);
      checkOutput("err_overrun", err_overrun, m_ovr);
      checkOutput("busy", busy, in_frame);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_en) cmd_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic int pickGap();
    if ($urandom_range(0, 9) == 0) return $urandom_range(98, 101);
    return $urandom_range(0, 2);
  endfunction

  initial begin
    int pulses;
    int at;
    logic [7:0] op, hi, lo, chk;

    #1;
    checkOutput("rst_valid", cmd_valid, 0);
    checkOutput("rst_op", cmd_op, 0);
    checkOutput("rst_arg", cmd_arg, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_errs", {err_chk, err_timeout, err_overrun}, 0);
    #20;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic valid frame with a ready consumer
    cmd_ready = 1'b1;
    applyStimulus(8'hAA, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0); applyStimulus(8'h34, 0);
    applyStimulus(8'h27, 0);
    checkOutput("s035_valid", cmd_valid, 1);
    checkOutput("s035_op", cmd_op, 32'h01);
    checkOutput("s035_arg", cmd_arg, 32'h1234);
    checkOutput("s035_errs", {err_chk, err_timeout, err_overrun}, 0);
    @(posedge clk); #1;
    checkOutput("s035_drop", cmd_valid, 0);

    // Checksum mismatch
    applyStimulus(8'hAA, 0); applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h05, 0);
    applyStimulus(8'h00, 0);
    checkOutput("s036_err_chk", err_chk, 1);
    checkOutput("s036_valid", cmd_valid, 0);
    checkOutput("s036_busy", busy, 0);
    @(posedge clk); #1;
    checkOutput("s036_err_chk_end", err_chk, 0);

    // Inter-byte timeout after AA,01, then a clean frame
    applyStimulus(8'hAA, 0); applyStimulus(8'h01, 0);
    pulses = 0;
    at = 0;
    for (int i = 1; i <= 120; i++) begin
      @(posedge clk); #1;
      if (err_timeout) begin
        pulses++;
        at = i;
      end
    end
    checkOutput("s037_pulses", pulses, 1);
    checkOutput("s037_at", at, 100);
    applyStimulus(8'hAA, 0); applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h03, 0);
    checkOutput("s037_op", cmd_op, 32'h02);
    checkOutput("s037_arg", cmd_arg, 32'h0001);
    checkOutput("s037_valid", cmd_valid, 1);

    // A byte landing exactly on the timeout cycle keeps the frame alive
    applyStimulus(8'hAA, 0); applyStimulus(8'h01, 99);
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    checkOutput("edge_valid", cmd_valid, 1);
    checkOutput("edge_arg", cmd_arg, 32'h0001);

    // Overrun while the consumer stalls
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    applyStimulus(8'hAA, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hAA, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    checkOutput("s038_overrun", err_overrun, 1);
    checkOutput("s038_arg", cmd_arg, 32'h0001);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("s038_overrun_end", err_overrun, 0);
    checkOutput("s038_hold_arg", cmd_arg, 32'h0001);
    checkOutput("s038_hold_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("s038_drain", cmd_valid, 0);

    // Junk before sync, and SYNC value inside the frame treated as data
    applyStimulus(8'h55, 0); applyStimulus(8'h13, 0);
    applyStimulus(8'hAA, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'hAA, 0); applyStimulus(8'h00, 0);
    applyStimulus(8'hAB, 0);
    checkOutput("s039_op", cmd_op, 32'h01);
    checkOutput("s039_arg", cmd_arg, 32'hAA00);

    // Reset mid-frame
    applyStimulus(8'hAA, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("s040_valid", cmd_valid, 0);
    checkOutput("s040_op", cmd_op, 0);
    checkOutput("s040_arg", cmd_arg, 0);
    checkOutput("s040_busy", busy, 0);
    checkOutput("s040_errs", {err_chk, err_timeout, err_overrun}, 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'hAA, 0); applyStimulus(8'h02, 0);
    applyStimulus(8'h12, 0); applyStimulus(8'h34, 0);
    applyStimulus(8'h24, 0);
    checkOutput("s040_next_op", cmd_op, 32'h02);
    checkOutput("s040_next_arg", cmd_arg, 32'h1234);

    // Randomized traffic: good, corrupt and truncated frames plus junk bytes
    rnd_en = 1'b1;
    repeat (150) begin
      int kind;
      kind = $urandom_range(0, 9);
      op = ($urandom_range(0, 3) == 0) ? OP_NOTE : 8'($urandom);
      hi = 8'($urandom);
      lo = 8'($urandom);
      chk = op ^ hi ^ lo;
      if (kind == 7) chk = chk ^ (8'h01 << $urandom_range(0, 7));
      if (kind == 0) begin
        applyStimulus(8'($urandom), pickGap());
      end else if (kind == 8) begin
        applyStimulus(8'hAA, pickGap());
        applyStimulus(op, pickGap());
      end else begin
        applyStimulus(8'hAA, pickGap());
        applyStimulus(op, pickGap());
        applyStimulus(hi, pickGap());
        applyStimulus(lo, pickGap());
        applyStimulus(chk, pickGap());
      end
    end
    rnd_en = 1'b0;
    repeat (TMO + 5) begin
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
